td4_clk_ctrl: RTL and testbench

//  Parametrised execution-clock controller for the TD4 core. Replaces the fixed

---
 rtl/td4_clk_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_td4_clk_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_clk_ctrl.sv
// td4_clk_ctrl: execution-clock controller for the TD4 core.
// Produces a one-cycle clock enable (cpu_ce) from a selectable prescaler tap.
// Four modes: halt, free run, debounced single step, and N-step burst.
// Also keeps a count of retired steps for the register display.
// Optional feature macro: TD4_CLK_BREAKPOINT_EN. When it is defined, a PC
// breakpoint can stop RUN mode.
module td4_clk_ctrl #(
    parameter int CNT_W   = 28,
    parameter int DSEL_W  = 5,
    parameter int DEB_W   = 18,
    parameter int BURST_N = 16,
    parameter int PC_W    = 4,
    parameter int STEP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_n,
    input  logic [1:0]        mode,
    input  logic [DSEL_W-1:0] div_sel,
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              bp_ena,
    output logic              cpu_ce,
    output logic              busy,
    output logic              bp_hit,
    output logic [STEP_W-1:0] step_cnt
);

    localparam int BURST_W = $clog2(BURST_N + 1);
    localparam int TAP_W   = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BURST = 2'b11
    } state_t;

    state_t state_reg, state_next;

    // Key conditioning.
    logic             key_meta_reg, key_sync_reg;
    logic             key_filt_reg, key_filt_d_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             key_press;

    // Prescaler and tap-edge detection.
    logic [CNT_W-1:0] presc_reg;
    logic [TAP_W-1:0] tap_sel;
    logic             tap_bit, tap_prev_reg, tick;

    // Work tracking.
    logic               pending_reg, pending_next;
    logic [BURST_W-1:0] burst_reg, burst_next;
    logic               ce_reg, ce_next;
    logic [STEP_W-1:0]  step_cnt_reg;
`ifdef TD4_CLK_BREAKPOINT_EN
    logic bp_hit_reg, bp_hit_next;
    logic skip_reg, skip_next;
`endif

    // Two-flop synchroniser. The idle (released) level of the key is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_reg <= 1'b1;
            key_sync_reg <= 1'b1;
        end else begin
            key_meta_reg <= key_n;
            key_sync_reg <= key_meta_reg;
        end
    end

    // Debounce filter.
    // The filtered level follows the input only after 2^DEB_W
    // consecutive samples that differ from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_reg    <= '0;
            key_filt_reg   <= 1'b1;
            key_filt_d_reg <= 1'b1;
        end else begin
            key_filt_d_reg <= key_filt_reg;
            if (key_sync_reg == key_filt_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == {DEB_W{1'b1}}) begin
                deb_cnt_reg  <= '0;
                key_filt_reg <= key_sync_reg;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end
    end

    // A press is the filtered 1->0 edge; it lasts a single cycle.
    assign key_press = key_filt_d_reg & ~key_filt_reg;

    // Clamp the tap select to the top bit of the prescaler.
    always_comb begin
        if (32'(div_sel) > 32'(CNT_W - 1)) begin
            tap_sel = TAP_W'(CNT_W - 1);
        end else begin
            tap_sel = TAP_W'(div_sel);
        end
    end

    assign tap_bit = presc_reg[tap_sel];
    assign tick    = tap_bit & ~tap_prev_reg;

    // Free-running prescaler, plus the previous tap value for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg    <= '0;
            tap_prev_reg <= 1'b0;
        end else begin
            presc_reg    <= presc_reg + CNT_W'(1);
            tap_prev_reg <= tap_bit;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_HALT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: MODE is sampled every cycle.
    always_comb begin
        state_next = state_t'(mode);
    end

    // FSM outputs.
    // The enable and the bookkeeping updates are evaluated against the
    // current state. A mode change therefore takes effect one cycle later.
    always_comb begin
        ce_next      = 1'b0;
        pending_next = pending_reg;
        burst_next   = burst_reg;
`ifdef TD4_CLK_BREAKPOINT_EN
        bp_hit_next  = bp_hit_reg;
        skip_next    = skip_reg;
`endif
        case (state_reg)
            ST_RUN: begin
`ifdef TD4_CLK_BREAKPOINT_EN
                // A press while stopped releases the breakpoint.
                // The next tick then steps past the breakpoint address.
                if (key_press && bp_hit_reg) begin
                    bp_hit_next = 1'b0;
                    skip_next   = 1'b1;
                end
                if (tick) begin
                    if (bp_hit_reg) begin
                        ce_next = 1'b0;
                    end else if (skip_reg) begin
                        ce_next   = 1'b1;
                        skip_next = 1'b0;
                    end else if (bp_ena && (pc == bp_addr)) begin
                        bp_hit_next = 1'b1;
                    end else begin
                        ce_next = 1'b1;
                    end
                end
`else
                ce_next = tick;
`endif
            end
            ST_STEP: begin
                if (tick && pending_reg) begin
                    ce_next      = 1'b1;
                    pending_next = 1'b0;
                end
                if (key_press && !pending_reg) begin
                    pending_next = 1'b1;
                end
            end
            ST_BURST: begin
                if (tick && (burst_reg != '0)) begin
                    ce_next    = 1'b1;
                    burst_next = burst_reg - BURST_W'(1);
                end
                if (key_press && (burst_reg == '0)) begin
                    burst_next = BURST_W'(BURST_N);
                end
            end
            default: begin
                ce_next = 1'b0;
            end
        endcase
        // Leaving a mode discards the work that belongs to that mode.
        if (state_next != state_reg) begin
            case (state_reg)
                ST_STEP:  pending_next = 1'b0;
                ST_BURST: burst_next   = '0;
`ifdef TD4_CLK_BREAKPOINT_EN
                ST_RUN: begin
                    bp_hit_next = 1'b0;
                    skip_next   = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    // Registered outputs and work state.
    // step_cnt advances in the same cycle that the enable is shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_reg       <= 1'b0;
            pending_reg  <= 1'b0;
            burst_reg    <= '0;
            step_cnt_reg <= '0;
        end else begin
            ce_reg      <= ce_next;
            pending_reg <= pending_next;
            burst_reg   <= burst_next;
            if (ce_next) begin
                step_cnt_reg <= step_cnt_reg + STEP_W'(1);
            end
        end
    end

`ifdef TD4_CLK_BREAKPOINT_EN
    // Breakpoint status: the sticky hit flag and the step-past flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            bp_hit_reg <= 1'b0;
            skip_reg   <= 1'b0;
        end else begin
            bp_hit_reg <= bp_hit_next;
            skip_reg   <= skip_next;
        end
    end

    assign bp_hit = bp_hit_reg;
`else
    // Without the breakpoint feature the PC compare inputs have no effect.
    logic unused_bp_inputs;
    assign unused_bp_inputs = ^{pc, bp_addr, bp_ena};
    assign bp_hit = 1'b0;
`endif

    assign cpu_ce   = ce_reg;
    assign busy     = pending_reg | (burst_reg != '0);
    assign step_cnt = step_cnt_reg;

endmodule

// File: tb/tb_td4_clk_ctrl.sv
// tb_td4_clk_ctrl: directed self-checking bench for td4_clk_ctrl.
// Bench parameters: CNT_W=8, DEB_W=4, BURST_N=5, STEP_W=8.
`timescale 1ns/1ps
module tb_td4_clk_ctrl;

    localparam int CNT_W   = 8;
    localparam int DSEL_W  = 5;
    localparam int DEB_W   = 4;
    localparam int BURST_N = 5;
    localparam int PC_W    = 4;
    localparam int STEP_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              key_n;
    logic [1:0]        mode;
    logic [DSEL_W-1:0] div_sel;
    logic [PC_W-1:0]   pc = '0;
    logic [PC_W-1:0]   bp_addr;
    logic              bp_ena;
    logic              cpu_ce;
    logic              busy;
    logic              bp_hit;
    logic [STEP_W-1:0] step_cnt;

    int errors = 0;
    int checks = 0;

    // Statistics gathered by the monitor.
    int ce_count = 0;
    int busy_cnt = 0;
    int b2b = 0;
    int cyc = 0;
    int last_ce_cyc = 0;
    int last_interval = 0;
    logic busy_at_ce = 1'b0;
    logic prev_ce = 1'b0;

    td4_clk_ctrl #(
        .CNT_W(CNT_W), .DSEL_W(DSEL_W), .DEB_W(DEB_W),
        .BURST_N(BURST_N), .PC_W(PC_W), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .mode(mode),
        .div_sel(div_sel), .pc(pc), .bp_addr(bp_addr), .bp_ena(bp_ena),
        .cpu_ce(cpu_ce), .busy(busy), .bp_hit(bp_hit), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge.
    // It also models the core PC, which advances once per enable.
    always @(negedge clk) begin
        cyc++;
        if (reset) pc = '0;
        else if (cpu_ce) pc = pc + 1'b1;
        if (busy) busy_cnt++;
        if (cpu_ce) begin
            ce_count++;
            busy_at_ce    = busy;
            last_interval = cyc - last_ce_cyc;
            last_ce_cyc   = cyc;
            if (prev_ce) b2b++;
        end
        prev_ce = cpu_ce;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input int low_cycles);
        key_n = 1'b0;
        step(low_cycles);
        key_n = 1'b1;
        step(25);
    endtask

    task automatic wait_ce(input int target, input int budget);
        int k;
        k = 0;
        while (ce_count < target && k < budget) begin
            step(1);
            k++;
        end
    endtask

    int base;
    int bbase;
    int k;

    initial begin
        reset = 1'b1; key_n = 1'b1; mode = 2'b00; div_sel = 5'd2;
        bp_addr = 4'h3; bp_ena = 1'b0;
        step(3);
        check("reset_cpu_ce", cpu_ce, 0);
        check("reset_busy", busy, 0);
        check("reset_bp_hit", bp_hit, 0);
        check("reset_step_cnt", step_cnt, 0);
        reset = 1'b0;
        step(2);

        // RUN at DIV_SEL=2: one enable every 8 cycles.
        base = ce_count;
        mode = 2'b01;
        wait_ce(base + 10, 200);
        check("run_step_cnt", step_cnt, 10);
        check("run_interval", last_interval, 8);
        check("run_busy", busy, 0);
        mode = 2'b00;
        step(30);
        check("halt_no_ce", ce_count, base + 10);
        $display("run div2: ce=%0d step_cnt=%0d interval=%0d", ce_count - base, step_cnt, last_interval);

        // RUN at DIV_SEL=0: period 2, never back to back.
        div_sel = 5'd0;
        base = ce_count;
        mode = 2'b01;
        wait_ce(base + 6, 100);
        mode = 2'b00;
        check("div0_interval", last_interval, 2);
        check("div0_no_b2b", b2b, 0);
        step(5);
        $display("run div0: interval=%0d", last_interval);

        // STEP: a bounce gives nothing; a real press gives exactly one enable.
        div_sel = 5'd2;
        mode = 2'b10;
        step(5);
        base = ce_count; bbase = busy_cnt;
        press(3);
        step(20);
        check("bounce_no_ce", ce_count, base);
        check("bounce_no_busy", busy_cnt, bbase);
        press(20);
        step(20);
        check("step_one_ce", ce_count, base + 1);
        check("step_busy_seen", busy_cnt > bbase, 1);
        check("step_busy_at_ce", busy_at_ce, 0);
        check("step_busy_end", busy, 0);
        $display("step: ce=%0d busy_cycles=%0d", ce_count - base, busy_cnt - bbase);

        // BURST: a second press during the burst is ignored; five enables.
        div_sel = 5'd4;
        mode = 2'b11;
        step(5);
        base = ce_count; bbase = busy_cnt;
        press(20);
        press(20);
        step(200);
        check("burst_five", ce_count, base + 5);
        check("burst_busy_at_last", busy_at_ce, 0);
        check("burst_busy_seen", busy_cnt > bbase, 1);
        check("burst_busy_end", busy, 0);
        $display("burst: ce=%0d", ce_count - base);

        // A burst that is abandoned by switching to HALT.
        base = ce_count;
        press(20);
        wait_ce(base + 2, 150);
        mode = 2'b00;
        step(1);
        check("halt_ce_stop", cpu_ce, 0);
        step(2);
        check("halt_busy_clear", busy, 0);
        step(100);
        check("halt_no_more_ce", ce_count, base + 2);
        mode = 2'b11;
        step(100);
        check("burst_count_cleared", ce_count, base + 2);
        $display("burst->halt: ce=%0d busy=%0d", ce_count - base, busy);

        // Reset while a step is pending.
        mode = 2'b10;
        div_sel = 5'd7;
        step(5);
        key_n = 1'b0;
        k = 0;
        while (!busy && k < 60) begin
            step(1);
            k++;
        end
        check("pending_seen", busy, 1);
        key_n = 1'b1;
        reset = 1'b1;
        step(2);
        base = ce_count;
        reset = 1'b0;
        step(300);
        check("reset_step_no_ce", ce_count, base);
        check("reset_step_cnt_zero", step_cnt, 0);
        check("reset_step_busy", busy, 0);
        $display("reset mid-step: ce=%0d step_cnt=%0d", ce_count - base, step_cnt);

        // step_cnt wraps from all-ones to zero.
        div_sel = 5'd0;
        base = ce_count;
        mode = 2'b01;
        wait_ce(base + 255, 700);
        check("wrap_ff", step_cnt, 8'hFF);
        wait_ce(base + 256, 10);
        check("wrap_zero", step_cnt, 0);
        mode = 2'b00;
        step(5);
        $display("wrap: step_cnt=%0h", step_cnt);

        // Breakpoint at address 3.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        bp_ena = 1'b1; bp_addr = 4'h3; div_sel = 5'd2;
        step(2);
        base = ce_count;
        mode = 2'b01;
        step(100);
`ifdef TD4_CLK_BREAKPOINT_EN
        check("bp_stop_ce", ce_count, base + 3);
        check("bp_hit_set", bp_hit, 1);
        check("bp_pc", pc, 3);
        press(20);
        check("bp_cleared", bp_hit, 0);
        check("bp_stepped", ce_count > base + 3, 1);
        step(40);
        check("bp_resumed", ce_count >= base + 8, 1);
`else
        check("nobp_hit", bp_hit, 0);
        check("nobp_runs", ce_count >= base + 10, 1);
`endif
        mode = 2'b00;
        step(5);
        $display("breakpoint: ce=%0d pc=%0h bp_hit=%0d", ce_count - base, pc, bp_hit);

        check("no_back_to_back", b2b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
